pwm_capture: RTL and testbench

//   Measures an incoming PWM signal (e.g. an RC receiver channel or a loop-back of our own PWM output).

---
 rtl/pwm_capture.sv | 166 ++++++++++++++++
 tb/tb_pwm_capture.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM period / high-time capture with loss-of-signal timeout.
// Define PWM_CAP_DUTY_EN to add a sequential divider that also reports a 10-bit duty word.
module pwm_capture #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 2_500_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [9:0]       duty,
  output logic             valid,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, hi_lat, hi_nxt;
  logic             sync1, sync2, sync_d;
  logic             rise, fall, capture, to_evt;

  assign rise = sync2 & ~sync_d;
  assign fall = ~sync2 & sync_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync_d <= 1'b0;
      state  <= IDLE;
      cnt    <= '0;
      hi_lat <= '0;
    end else begin
      sync1  <= pwm_in;
      sync2  <= sync1;
      sync_d <= sync2;
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      hi_lat <= hi_nxt;
    end
  end

  // An edge in the same cycle as the timeout count takes priority.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hi_nxt    = hi_lat;
    capture   = 1'b0;
    to_evt    = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = HIGH;
          cnt_nxt   = ONE;
        end
      end
      HIGH: begin
        if (fall) begin
          hi_nxt    = cnt;
          state_nxt = LOW;
          cnt_nxt   = cnt + ONE;
        end else if (!rise && cnt == TO_CNT) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          to_evt    = 1'b1;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      LOW: begin
        if (rise) begin
          capture   = 1'b1;
          state_nxt = HIGH;
          cnt_nxt   = ONE;
        end else if (!fall && cnt == TO_CNT) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          to_evt    = 1'b1;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef PWM_CAP_DUTY_EN
  // Restoring divider: rem starts at high (< period), so each step yields one quotient bit.
  logic [3:0]       div_cnt;
  logic [CNT_W-1:0] div_p, div_h, rem, rem_nxt;
  logic [CNT_W:0]   rem2, diff;
  logic [9:0]       quo;
  logic             ge;

  assign rem2    = {rem, 1'b0};
  assign diff    = rem2 - {1'b0, div_p};
  assign ge      = rem2 >= {1'b0, div_p};
  assign rem_nxt = ge ? diff[CNT_W-1:0] : rem2[CNT_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt   <= '0;
      div_p     <= '0;
      div_h     <= '0;
      rem       <= '0;
      quo       <= '0;
      period    <= '0;
      high_time <= '0;
      duty      <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid <= 1'b0;
      // Busy covers the running steps and the publish cycle; captures then are dropped.
      if (capture && div_cnt == 4'd0 && !valid) begin
        div_p   <= cnt;
        div_h   <= hi_lat;
        rem     <= hi_lat;
        quo     <= '0;
        div_cnt <= 4'd10;
      end else if (div_cnt != 4'd0) begin
        rem     <= rem_nxt;
        quo     <= {quo[8:0], ge};
        div_cnt <= div_cnt - 4'd1;
        if (div_cnt == 4'd1) begin
          period    <= div_p;
          high_time <= div_h;
          duty      <= {quo[8:0], ge};
          valid     <= 1'b1;
          timeout   <= 1'b0;
        end
      end
      if (to_evt) timeout <= 1'b1;
    end
  end
`else
  assign duty = '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (capture) begin
        period    <= cnt;
        high_time <= hi_lat;
        valid     <= 1'b1;
        timeout   <= 1'b0;
      end
      if (to_evt) timeout <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: table-driven waveforms, scoreboard of expected captures, timeout/reset sequences.
module tb_pwm_capture;
  localparam int CNT_W = 32;
  localparam int TO    = 3000;
`ifdef PWM_CAP_DUTY_EN
  localparam int LAT  = 13;
  localparam bit DUTY = 1'b1;
`else
  localparam int LAT  = 3;
  localparam bit DUTY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] period, high_time;
  logic [9:0]       duty;
  logic             valid, timeout;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .pwm_in(pwm_in),
    .period(period), .high_time(high_time), .duty(duty),
    .valid(valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int p; int h; int n; int d;} vec_t;
  typedef struct {int p; int h; int d; int at;} exp_t;

  vec_t vecs[10];
  exp_t sbq[$];
  int   checks = 0, failures = 0;
  int   prev_p, prev_h, prev_d, last_acc = -1000;
  bit   have_prev = 1'b0;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A rising edge closes the previous period; a busy divider drops captures closer than 12 cycles.
  task automatic on_rise();
    if (have_prev && (!DUTY || cyc - last_acc >= 12)) begin
      sbq.push_back('{prev_p, prev_h, DUTY ? prev_d : 0, cyc});
      last_acc = cyc;
    end
  endtask

  task automatic wave(int p, int h, int d);
    on_rise();
    pwm_in = 1'b1;
    repeat (h) @(posedge clk);
    #1 pwm_in = 1'b0;
    repeat (p - h) @(posedge clk);
    #1;
    prev_p = p; prev_h = h; prev_d = d; have_prev = 1'b1;
  endtask

  always @(negedge clk) begin
    if (reset && valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("period", period, e.p);
        chk("high_time", high_time, e.h);
        chk("duty", duty, e.d);
        chk("timeout_at_valid", timeout, 0);
        chk("valid_latency", cyc - e.at, LAT);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e_cyc;
    vecs[0] = '{2000,  500, 2,  256};
    vecs[1] = '{2000, 1000, 3,  512};
    vecs[2] = '{2000, 1500, 2,  768};
    vecs[3] = '{  20,    5, 4,  256};
    vecs[4] = '{  37,   11, 3,  304};
    vecs[5] = '{  13,   12, 3,  945};
    vecs[6] = '{  10,    3, 6,  307};
    vecs[7] = '{   4,    1, 6,  256};
    vecs[8] = '{ 100,    1, 2,   10};
    vecs[9] = '{ 100,   99, 2, 1013};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_period", period, 0);
    chk("rst_high_time", high_time, 0);
    chk("rst_duty", duty, 0);
    chk("rst_valid", valid, 0);
    chk("rst_timeout", timeout, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      for (int k = 0; k < vecs[i].n; k++)
        wave(vecs[i].p, vecs[i].h, vecs[i].d);

    // Close the last period, then hold high until the timeout fires.
    on_rise();
    e_cyc = cyc;
    pwm_in = 1'b1;
    while (cyc < e_cyc + 2 + TO) begin
      @(posedge clk); #1;
    end
    chk("timeout_before", timeout, 0);
    @(posedge clk); #1;
    chk("timeout_after", timeout, 1);
    chk("hold_period", period, 100);
    chk("hold_high_time", high_time, 99);
    chk("hold_duty", duty, DUTY ? 1013 : 0);

    // Resume: first valid only after a full period following the resume rising edge.
    pwm_in = 1'b0;
    have_prev = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("timeout_idle", timeout, 1);
    wave(40, 10, 256);
    chk("timeout_first_period", timeout, 1);
    wave(40, 10, 256);
    wave(40, 10, 256);
    on_rise();
    pwm_in = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("timeout_cleared", timeout, 0);

    // Asynchronous reset mid-HIGH wipes outputs at once.
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_period", period, 0);
    chk("mid_rst_high_time", high_time, 0);
    chk("mid_rst_duty", duty, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_timeout", timeout, 0);
    pwm_in = 1'b0;
    have_prev = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) wave(20, 5, 256);
    on_rise();
    pwm_in = 1'b1;
    repeat (LAT + 5) @(posedge clk);
    #1;
    chk("queue_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
